// File: rtl/opt_reg_pipe_if.sv
// Bus bundle for the opt_reg_pipe delay line: control, payload in, tagged payload out and occupancy.
// The source/consumer side takes the master modport; the delay line itself takes slave.
interface opt_reg_pipe_if #(
  parameter int DataWidth = 16,
  parameter int Depth     = 2
) ();
  logic                         en;
  logic                         flush;
  logic                         data_in_valid;
  logic [DataWidth-1:0]         data_in;
  logic                         res_valid;
  logic [DataWidth-1:0]         res;
  logic [$clog2(Depth+1)-1:0]   occ;

  modport master (
    output en, flush, data_in_valid, data_in,
    input  res_valid, res, occ
  );

  modport slave (
    input  en, flush, data_in_valid, data_in,
    output res_valid, res, occ
  );
endinterface

// File: rtl/opt_reg_pipe.sv
// Depth-stage registered delay line with a valid tag per stage, stall (en) and flush.
// Outputs come straight from the last stage; occ is the number of valid stages.
module opt_reg_pipe #(
  parameter int                   DataWidth = 16,
  parameter int                   Depth     = 2,
  parameter logic [DataWidth-1:0] ResetData = '0
) (
  input logic           clk,
  input logic           rst,
  opt_reg_pipe_if.slave bus
);

  localparam int OccWidth = $clog2(Depth + 1);

  logic [Depth-1:0]     v_q;
  logic [DataWidth-1:0] d_q [Depth];
  logic [OccWidth-1:0]  occ_sum;

  // Priority: rst > flush > en > hold. Flush clears tags only; payloads stay put.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      // NOTE: the payload array is reset on purpose so res shows ResetData after reset;
      // payload flops without a reset requirement would normally be left unreset.
      for (int i = 0; i < Depth; i++) d_q[i] <= ResetData;
    end else if (bus.flush) begin
      v_q <= '0;
    end else if (bus.en) begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value,
      // so the loop order is irrelevant and each stage really is one register deep.
      v_q[0] <= bus.data_in_valid;
      d_q[0] <= bus.data_in;
      for (int i = 1; i < Depth; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  always_comb begin
    // NOTE: assigning the default before the loop keeps this purely combinational (no latch).
    occ_sum = '0;
    for (int i = 0; i < Depth; i++) occ_sum = occ_sum + OccWidth'(v_q[i]);
  end

  assign bus.res_valid = v_q[Depth-1];
  assign bus.res       = d_q[Depth-1];
  assign bus.occ       = occ_sum;

endmodule
